mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Load/store initiator sitting between the processor's memory pipeline stage and the 512-word data memory. It accepts one byte-addressed load or store request at a time and drives the memory's `active`/`rw`/`index`/`inputMem` interface. It performs read-modify-write for byte and halfword stores, and returns aligned, extended load data with a one-cycle response pulse.

## Interface
- `MEM_DEPTH`, 512, number of 32-bit words in the data memory; valid word indices are 0..MEM_DEPTH-1.
- `clk`  in  1  clock; all state changes on posedge.
- `rst_n`  in  1  reset; synchronous and active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept; high only in IDLE.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved.
- `req_signed`  in  1  loads only: sign-extend when 1, zero-extend when 0.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `resp_valid`  out  1  one-cycle pulse at request completion.
- `resp_err`  out  1  qualified by `resp_valid`: misaligned, out-of-range or reserved size.
- `resp_rdata`  out  32  load result; 0 for stores and errors.
- `mem_active`  out  1  to memory `active`.
- `mem_rw`  out  1  to memory `rw`; 1 = write.
- `mem_index`  out  32  to memory `index`; word index = {2'b0, addr[31:2]}.
- `mem_wdata`  out  32  to memory `inputMem`.
- `mem_rdata`  in  32  from memory `outputMem`; valid in the cycle after a read is sampled.

## Operation
- States: IDLE, RD, RD_WAIT, WR, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, latch all request fields.
  - Then go to RESP with err if the request is invalid.
  - Otherwise: load -> RD; word store -> WR; byte/half store -> RD (RMW).
- Invalid request conditions:
  - size=11.
  - half with addr[0]=1.
  - word with addr[1:0]!=0.
  - addr[31:2] >= MEM_DEPTH.
- An invalid request never asserts `mem_active`.
- RD: `mem_active`=1, `mem_rw`=0, `mem_index`=latched index. Next state is RD_WAIT.
- RD_WAIT:
  - Capture `mem_rdata`.
  - Load: extract the lane, extend, then go to RESP.
  - RMW store: merge the new lane into the captured word, then go to WR.
- Lane rules:
  - Little-endian: byte k occupies bits [8k+7:8k].
  - Half at addr[1]=h occupies bits [16h+15:16h].
- WR: `mem_active`=1, `mem_rw`=1, `mem_wdata`=word or merged data. Next state is RESP.
- RESP: `resp_valid`=1 for exactly one cycle, then IDLE.
- `mem_active`, `mem_rw` and `resp_valid` decode combinationally from state. `mem_index` and `mem_wdata` come from registers.

## Timing
- Request accepted at edge N; `resp_valid` is high during the cycle starting at:
  - N+1 for an error.
  - N+2 for a word store.
  - N+3 for a load.
  - N+4 for a sub-word store.
- Back-to-back requests: the next accept edge is the edge ending RESP, i.e. one request per (latency+1) cycles.
- Reset values: state=IDLE, `req_ready`=1, and every other output 0, including `mem_index`, `mem_wdata` and `resp_rdata`.
- Reset mid-operation:
  - Returns to IDLE at the reset edge, with no response issued.
  - The memory has no reset, so a write driven in WR during the reset edge still commits.
  - An RMW reset before WR never writes.
- `req_valid` outside IDLE is ignored, not queued.

## Structure
- Package `mem_access_pkg`: size encodings, state enum, and `MEM_DEPTH` default.
- Sub-module `mem_lane_align` (combinational): extract + sign/zero extend for loads, and lane merge for stores, from size, addr[1:0] and signed.

## Test plan
- Word store, addr 0x10, data 0xDEADBEEF:
  - N+1: `mem_active`=1, `mem_rw`=1, `mem_index`=4, `mem_wdata`=0xDEADBEEF.
  - N+2: `resp_valid`=1, `resp_err`=0, `resp_rdata`=0.
- Byte loads at addr 0x13 after that store:
  - Signed -> `resp_rdata`=0xFFFFFFDE at N+3.
  - Unsigned -> 0x000000DE.
- Half store, addr 0x12, data 0x00001234:
  - RMW read of index 4 at N+1.
  - N+3: write of 0x1234BEEF.
  - N+4: resp.
  - A following word load at addr 0x10 returns 0x1234BEEF.
- Error requests each give `resp_err`=1 at N+1 with `mem_active` never high:
  - Word load at 0x06.
  - Half load at 0x11.
  - Word load at 0x800 (index 512).
  - size=11.
- `req_valid` held high with two loads:
  - Second accepted at the edge ending the first RESP.
  - `req_ready` low throughout RD/RD_WAIT/RESP.
- `rst_n`=0 during RD_WAIT of a half store:
  - No `mem_rw`=1 ever issued.
  - No `resp_valid`.
  - `req_ready`=1 the cycle after the reset edge.
  - Memory word unchanged.

Source files
------------

// File: rtl/mem_access_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_pkg
// Description : Shared encodings for the load/store memory access unit:
//               access-size codes, FSM state enum and default memory depth.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_access_pkg;

    // Number of 32-bit words in the attached data memory
    localparam int c_MEM_DEPTH = 512;

    // Access size encodings carried on req_size
    localparam logic [1:0] c_SIZE_BYTE = 2'b00;
    localparam logic [1:0] c_SIZE_HALF = 2'b01;
    localparam logic [1:0] c_SIZE_WORD = 2'b10;
    localparam logic [1:0] c_SIZE_RSVD = 2'b11;

    // Request sequencing states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD      = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_WR      = 3'd3,
        ST_RESP    = 3'd4
    } state_t;

endpackage : mem_access_pkg
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_lane_align
// Description : Combinational lane steering. Extracts and extends the
//               addressed byte/halfword of a memory word for loads, and
//               merges store data into the addressed lane for RMW stores.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addrLow,
    input  logic        i_isSigned,
    input  logic [31:0] i_memWord,
    input  logic [31:0] i_storeData,
    output logic [31:0] o_loadData,
    output logic [31:0] o_mergedData
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Select the addressed lane (little-endian) and build load / merge results
    always_comb begin
        w_byte       = i_memWord[{i_addrLow, 3'b000} +: 8];
        w_half       = i_addrLow[1] ? i_memWord[31:16] : i_memWord[15:0];
        o_loadData   = i_memWord;
        o_mergedData = i_storeData;
        case (i_size)
            c_SIZE_BYTE: begin
                o_loadData   = {{24{i_isSigned & w_byte[7]}}, w_byte};
                o_mergedData = i_memWord;
                o_mergedData[{i_addrLow, 3'b000} +: 8] = i_storeData[7:0];
            end
            c_SIZE_HALF: begin
                o_loadData   = {{16{i_isSigned & w_half[15]}}, w_half};
                o_mergedData = i_memWord;
                if (i_addrLow[1]) begin
                    o_mergedData[31:16] = i_storeData[15:0];
                end else begin
                    o_mergedData[15:0]  = i_storeData[15:0];
                end
            end
            default: begin
                o_loadData   = i_memWord;
                o_mergedData = i_storeData;
            end
        endcase
    end

endmodule : mem_lane_align
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : Single-outstanding load/store initiator in front of the data
//               memory. Validates requests, sequences read / write / RMW
//               cycles and returns aligned, extended load data.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int MEM_DEPTH = c_MEM_DEPTH
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic        mem_active,
    output logic        mem_rw,
    output logic [31:0] mem_index,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [31:0] c_DEPTH = 32'(MEM_DEPTH);

    state_t      r_state;
    state_t      w_nextState;

    logic        r_write;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [1:0]  r_addrLow;
    logic [31:0] r_storeData;
    logic        r_err;
    logic [31:0] r_memIndex;
    logic [31:0] r_memWdata;
    logic [31:0] r_respRdata;

    logic        w_accept;
    logic        w_misaligned;
    logic        w_outOfRange;
    logic        w_invalid;
    logic [31:0] w_loadData;
    logic [31:0] w_mergedData;

    assign w_accept     = (r_state == ST_IDLE) && req_valid;
    assign w_misaligned = ((req_size == c_SIZE_HALF) && req_addr[0]) ||
                          ((req_size == c_SIZE_WORD) && (req_addr[1:0] != 2'b00));
    assign w_outOfRange = ({2'b00, req_addr[31:2]} >= c_DEPTH);
    assign w_invalid    = (req_size == c_SIZE_RSVD) || w_misaligned || w_outOfRange;

    assign mem_index  = r_memIndex;
    assign mem_wdata  = r_memWdata;
    assign resp_rdata = r_respRdata;

    mem_lane_align u_laneAlign (
        .i_size       (r_size),
        .i_addrLow    (r_addrLow),
        .i_isSigned   (r_signed),
        .i_memWord    (mem_rdata),
        .i_storeData  (r_storeData),
        .o_loadData   (w_loadData),
        .o_mergedData (w_mergedData)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state selection and state-decoded handshake / memory strobes
    always_comb begin
        w_nextState = r_state;
        req_ready   = 1'b0;
        mem_active  = 1'b0;
        mem_rw      = 1'b0;
        resp_valid  = 1'b0;
        resp_err    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (w_invalid) begin
                        w_nextState = ST_RESP;
                    end else if (req_write && (req_size == c_SIZE_WORD)) begin
                        w_nextState = ST_WR;
                    end else begin
                        w_nextState = ST_RD;
                    end
                end
            end
            ST_RD: begin
                mem_active  = 1'b1;
                w_nextState = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                w_nextState = r_write ? ST_WR : ST_RESP;
            end
            ST_WR: begin
                mem_active  = 1'b1;
                mem_rw      = 1'b1;
                w_nextState = ST_RESP;
            end
            ST_RESP: begin
                resp_valid  = 1'b1;
                resp_err    = r_err;
                w_nextState = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Request latch plus registered memory index, write data and load result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_write     <= 1'b0;
            r_size      <= c_SIZE_BYTE;
            r_signed    <= 1'b0;
            r_addrLow   <= 2'b00;
            r_storeData <= 32'h0;
            r_err       <= 1'b0;
            r_memIndex  <= 32'h0;
            r_memWdata  <= 32'h0;
            r_respRdata <= 32'h0;
        end else begin
            if (w_accept) begin
                r_write     <= req_write;
                r_size      <= req_size;
                r_signed    <= req_signed;
                r_addrLow   <= req_addr[1:0];
                r_storeData <= req_wdata;
                r_err       <= w_invalid;
                r_memIndex  <= {2'b00, req_addr[31:2]};
                r_respRdata <= 32'h0;
                if (req_write && (req_size == c_SIZE_WORD)) begin
                    r_memWdata <= req_wdata;
                end
            end
            // Read data is only valid here, one cycle after the read strobe
            if (r_state == ST_RD_WAIT) begin
                if (r_write) begin
                    r_memWdata <= w_mergedData;
                end else begin
                    r_respRdata <= w_loadData;
                end
            end
        end
    end

endmodule : mem_access_unit
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Scoreboard bench for mem_access_unit with a behavioural
//               memory, a word-array reference model and randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        mem_active;
    logic        mem_rw;
    logic [31:0] mem_index;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    mem_access_unit #(.MEM_DEPTH(512)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata),
        .mem_active (mem_active),
        .mem_rw     (mem_rw),
        .mem_index  (mem_index),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Data memory: synchronous write, registered read, no reset
    logic [31:0] mem    [512];
    logic [31:0] refMem [512];
    logic [31:0] memRdata = 32'h0;
    assign mem_rdata = memRdata;

    always @(posedge clk) begin
        if (mem_active && (mem_index < 32'd512)) begin
            if (mem_rw) mem[mem_index] <= mem_wdata;
            else        memRdata <= mem[mem_index];
        end
    end

    // Edge counter: at a falling edge it holds the number of rising edges so far
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          acceptCycle;
        bit          err;
        logic [31:0] rdata;
        int          lat;
        int          nActive;
        int          nWrite;
        logic [31:0] idx;
        logic [31:0] wdata;
    } exp_t;

    exp_t q[$];
    int   checks     = 0;
    int   failures   = 0;
    bit   directed   = 1'b0;
    int   activeCnt  = 0;
    int   writeCnt   = 0;
    int   lastAccept = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: word-array semantics of one request, applied in order
    function automatic exp_t model(input bit wr, input logic [1:0] sz, input bit sg,
                                   input logic [31:0] addr, input logic [31:0] wd);
        exp_t        e;
        int          sh;
        logic [31:0] old;
        logic [31:0] v;
        logic [31:0] mask;
        e.acceptCycle = 0;
        e.idx    = addr >> 2;
        e.err    = (sz == 2'd3) || (sz == 2'd1 && (addr % 2) != 0) ||
                   (sz == 2'd2 && (addr % 4) != 0) || (e.idx >= 32'd512);
        e.rdata  = 32'h0;
        e.wdata  = 32'h0;
        e.nWrite = 0;
        if (e.err) begin
            e.lat = 1; e.nActive = 0;
        end else begin
            old = refMem[e.idx];
            sh  = 8 * int'(addr % 4);
            if (!wr) begin
                e.lat = 3; e.nActive = 1;
                if (sz == 2'd0) begin
                    v = (old >> sh) & 32'hFF;
                    if (sg && v >= 32'd128) v = v | 32'hFFFFFF00;
                end else if (sz == 2'd1) begin
                    v = (old >> sh) & 32'hFFFF;
                    if (sg && v >= 32'd32768) v = v | 32'hFFFF0000;
                end else begin
                    v = old;
                end
                e.rdata = v;
            end else begin
                if (sz == 2'd2) begin
                    v = wd; e.lat = 2; e.nActive = 1;
                end else begin
                    mask = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
                    v    = (old & ~mask) | ((wd << sh) & mask);
                    e.lat = 4; e.nActive = 2;
                end
                e.nWrite = 1;
                e.wdata  = v;
                refMem[e.idx] = v;
            end
        end
        return e;
    endfunction

    // Monitor: pops the scoreboard on each response, checks strobes every cycle
    always @(negedge clk) begin : monitor
        bit headAcc;
        if (!directed && rst_n) begin
            headAcc = (q.size() > 0) && (q[0].acceptCycle <= cyc);
            check("req_ready", {31'b0, req_ready}, {31'b0, !headAcc});
            if (!headAcc) begin
                check("mem_active_idle", {31'b0, mem_active}, 32'd0);
                check("resp_valid_idle", {31'b0, resp_valid}, 32'd0);
            end else begin
                if (mem_active) begin
                    activeCnt++;
                    check("mem_index", mem_index, q[0].idx);
                    if (mem_rw) begin
                        writeCnt++;
                        check("mem_wdata", mem_wdata, q[0].wdata);
                    end
                end
                if (resp_valid) begin
                    check("resp_err",   {31'b0, resp_err}, {31'b0, q[0].err});
                    check("resp_rdata", resp_rdata, q[0].rdata);
                    check("latency",    32'(cyc - q[0].acceptCycle + 1), 32'(q[0].lat));
                    check("active_cycles", 32'(activeCnt), 32'(q[0].nActive));
                    check("write_cycles",  32'(writeCnt),  32'(q[0].nWrite));
                    void'(q.pop_front());
                    activeCnt = 0;
                    writeCnt  = 0;
                end
            end
        end
    end

    // Present a request (valid stays high) and wait for it to be taken
    task automatic issue(input bit wr, input logic [1:0] sz, input bit sg,
                         input logic [31:0] addr, input logic [31:0] wd);
        exp_t e;
        int   waitCnt = 0;
        req_write  = wr;
        req_size   = sz;
        req_signed = sg;
        req_addr   = addr;
        req_wdata  = wd;
        req_valid  = 1'b1;
        while (!req_ready && waitCnt < 40) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!req_ready) begin
            check("accept_timeout", {31'b0, req_ready}, 32'd1);
            req_valid = 1'b0;
            return;
        end
        e = model(wr, sz, sg, addr, wd);
        e.acceptCycle = cyc + 1;
        lastAccept    = e.acceptCycle;
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        int waitCnt = 0;
        req_valid = 1'b0;
        while (q.size() != 0 && waitCnt < 50) begin
            @(negedge clk);
            waitCnt++;
        end
        if (q.size() != 0) check("drain_timeout", 32'(q.size()), 32'd0);
        @(negedge clk);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int          firstAccept;
        int          badWords;
        int          rwSeen;
        int          respSeen;
        int          r;
        bit          wr;
        bit          sg;
        logic [1:0]  sz;
        logic [31:0] addr;
        logic [31:0] preWord;

        for (int i = 0; i < 512; i++) begin
            mem[i]    = $urandom;
            refMem[i] = mem[i];
        end
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_req_ready",  {31'b0, req_ready},  32'd1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_resp_err",   {31'b0, resp_err},   32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_mem_active", {31'b0, mem_active}, 32'd0);
        check("rst_mem_rw",     {31'b0, mem_rw},     32'd0);
        check("rst_mem_index",  mem_index, 32'd0);
        check("rst_mem_wdata",  mem_wdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed sequence: word store, byte loads, half RMW store, readback
        issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
        idle(2);
        issue(1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
        issue(1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
        issue(1'b1, 2'd1, 1'b0, 32'h12, 32'h00001234);
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        drain();
        check("half_rmw_word", refMem[4], 32'h1234BEEF);

        // Error requests
        issue(1'b0, 2'd2, 1'b0, 32'h06,  32'h0);
        issue(1'b0, 2'd1, 1'b0, 32'h11,  32'h0);
        issue(1'b0, 2'd2, 1'b0, 32'h800, 32'h0);
        issue(1'b0, 2'd3, 1'b0, 32'h20,  32'h0);
        issue(1'b1, 2'd0, 1'b0, 32'h800, 32'h55);
        issue(1'b0, 2'd2, 1'b0, 32'h7FC, 32'h0);
        drain();

        // Two loads with valid held high
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        firstAccept = lastAccept;
        issue(1'b0, 2'd1, 1'b1, 32'h12, 32'h0);
        check("b2b_accept_gap", 32'(lastAccept - firstAccept), 32'd4);
        drain();

        // Reset during RD_WAIT of a half store
        directed = 1'b1;
        preWord  = mem[4];
        req_write = 1'b1; req_size = 2'd1; req_signed = 1'b0;
        req_addr = 32'h12; req_wdata = 32'h00005555; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check("rmw_rd_active", {31'b0, mem_active}, 32'd1);
        check("rmw_rd_rw",     {31'b0, mem_rw},     32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_req_ready",  {31'b0, req_ready},  32'd1);
        check("midrst_mem_active", {31'b0, mem_active}, 32'd0);
        check("midrst_mem_index",  mem_index,  32'd0);
        check("midrst_mem_wdata",  mem_wdata,  32'd0);
        check("midrst_resp_rdata", resp_rdata, 32'd0);
        rst_n    = 1'b1;
        rwSeen   = (mem_rw ? 1 : 0);
        respSeen = (resp_valid ? 1 : 0);
        repeat (6) begin
            @(negedge clk);
            rwSeen   += (mem_rw ? 1 : 0);
            respSeen += (resp_valid ? 1 : 0);
        end
        check("midrst_writes", 32'(rwSeen),   32'd0);
        check("midrst_resps",  32'(respSeen), 32'd0);
        check("midrst_mem_word", mem[4], preWord);
        directed = 1'b0;

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            wr = 1'($urandom_range(0, 1));
            sg = 1'($urandom_range(0, 1));
            r  = $urandom_range(0, 9);
            sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            r  = $urandom_range(0, 15);
            if (r == 0)      addr = $urandom;
            else if (r == 1) addr = 32'h7F8 + 32'($urandom_range(0, 15));
            else             addr = 32'($urandom_range(0, 63));
            issue(wr, sz, sg, addr, $urandom);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        drain();

        badWords = 0;
        for (int i = 0; i < 512; i++) begin
            if (mem[i] !== refMem[i]) badWords++;
        end
        check("mem_image", 32'(badWords), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mem_access_unit
`default_nettype wire
